imem_dmem_port_arbiter: RTL and testbench

- Shares one unified memory port between the fetch stage's I-side and the memory stage's D-side.
- One transaction in flight at a time.
- D-side has default priority; a starvation counter guarantees forward progress for fetch.
- Fetch-side flush support discards responses for I-fetches made stale by a redirect (br_en / flush_pipeline).

---
 rtl/imem_dmem_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_imem_dmem_port_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_dmem_port_arbiter.sv
// Shares one unified memory port between instruction fetch and data access.
// One transaction in flight; data side wins by default, bounded by a starvation counter.
module imem_dmem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_addr,
    input  logic [3:0]  i_rmask,
    input  logic        i_flush,
    output logic [31:0] i_rdata,
    output logic        i_resp,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_rmask,
    input  logic [3:0]  d_wmask,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_resp,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_rmask,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    typedef enum logic [2:0] {
        IDLE,
        I_ISSUE,
        I_WAIT,
        D_ISSUE,
        D_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             drop_q, drop_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [3:0]       mem_rmask_q, mem_rmask_d;
    logic [3:0]       mem_wmask_q, mem_wmask_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;

    logic i_req_ok;
    logic d_req;
    logic i_owner;
    logic d_owner;
    logic grant_i;
    logic grant_d;

    always_comb begin
        // A fetch being redirected this very cycle is not worth granting.
        i_req_ok = (i_rmask != 4'h0) && !i_flush;
        d_req    = ((d_rmask | d_wmask) != 4'h0);
        i_owner  = (state_q == I_ISSUE) || (state_q == I_WAIT);
        d_owner  = (state_q == D_ISSUE) || (state_q == D_WAIT);

        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state_q == IDLE) begin
            if (d_req && !(i_req_ok && (starve_cnt_q >= LIMIT))) begin
                grant_d = 1'b1;
            end else if (i_req_ok) begin
                grant_i = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        drop_d       = drop_q;
        mem_addr_d   = mem_addr_q;
        mem_rmask_d  = 4'h0;
        mem_wmask_d  = 4'h0;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                if (grant_i) begin
                    state_d      = I_ISSUE;
                    mem_addr_d   = i_addr;
                    mem_rmask_d  = i_rmask;
                    mem_wdata_d  = 32'h0;
                    starve_cnt_d = '0;
                end else if (grant_d) begin
                    state_d     = D_ISSUE;
                    mem_addr_d  = d_addr;
                    mem_rmask_d = d_rmask;
                    mem_wmask_d = d_wmask;
                    mem_wdata_d = d_wdata;
                    if (i_req_ok && (starve_cnt_q < LIMIT)) begin
                        starve_cnt_d = starve_cnt_q + CNT_W'(1);
                    end
                end
            end
            I_ISSUE, I_WAIT: begin
                if (mem_resp) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                end else begin
                    state_d = I_WAIT;
                    if (i_flush) begin
                        drop_d = 1'b1;
                    end
                end
            end
            D_ISSUE, D_WAIT: begin
                state_d = mem_resp ? IDLE : D_WAIT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            drop_q       <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_rmask_q  <= 4'h0;
            mem_wmask_q  <= 4'h0;
            mem_wdata_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            drop_q       <= drop_d;
            mem_addr_q   <= mem_addr_d;
            mem_rmask_q  <= mem_rmask_d;
            mem_wmask_q  <= mem_wmask_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Responses route straight through; a flush in the response cycle still suppresses it.
    assign i_resp  = mem_resp && i_owner && !drop_q && !i_flush;
    assign i_rdata = i_owner ? mem_rdata : 32'h0;
    assign d_resp  = mem_resp && d_owner;
    assign d_rdata = d_owner ? mem_rdata : 32'h0;

    assign mem_addr  = mem_addr_q;
    assign mem_rmask = mem_rmask_q;
    assign mem_wmask = mem_wmask_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// Directed bench: a cycle table of inputs/expected outputs, then a grant-order sequence
// with both requesters continuously pending.
module tb_imem_dmem_port_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] i_addr;
    logic [3:0]  i_rmask;
    logic        i_flush;
    logic [31:0] i_rdata;
    logic        i_resp;
    logic [31:0] d_addr;
    logic [3:0]  d_rmask;
    logic [3:0]  d_wmask;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_resp;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    int n_checks = 0;
    int n_fail   = 0;

    imem_dmem_port_arbiter #(
        .STARVE_LIMIT(4),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_addr(i_addr),
        .i_rmask(i_rmask),
        .i_flush(i_flush),
        .i_rdata(i_rdata),
        .i_resp(i_resp),
        .d_addr(d_addr),
        .d_rmask(d_rmask),
        .d_wmask(d_wmask),
        .d_wdata(d_wdata),
        .d_rdata(d_rdata),
        .d_resp(d_resp),
        .mem_addr(mem_addr),
        .mem_rmask(mem_rmask),
        .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_resp(mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  i_rmask;
        logic [31:0] i_addr;
        logic        i_flush;
        logic [3:0]  d_rmask;
        logic [3:0]  d_wmask;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        mem_resp;
        logic [31:0] mem_rdata;
        logic        e_i_resp;
        logic [31:0] e_i_rdata;
        logic        e_d_resp;
        logic [31:0] e_d_rdata;
        logic [31:0] e_mem_addr;
        logic [3:0]  e_mem_rmask;
        logic [3:0]  e_mem_wmask;
        logic [31:0] e_mem_wdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rs, input logic [3:0] irm, input logic [31:0] ia, input logic ifl,
        input logic [3:0] drm, input logic [3:0] dwm, input logic [31:0] da, input logic [31:0] dwd,
        input logic mr, input logic [31:0] mrd,
        input logic eir, input logic [31:0] eird, input logic edr, input logic [31:0] edrd,
        input logic [31:0] ema, input logic [3:0] erm, input logic [3:0] ewm, input logic [31:0] ewd);
        vec_t v;
        v.rst = rs;        v.i_rmask = irm;    v.i_addr = ia;      v.i_flush = ifl;
        v.d_rmask = drm;   v.d_wmask = dwm;    v.d_addr = da;      v.d_wdata = dwd;
        v.mem_resp = mr;   v.mem_rdata = mrd;
        v.e_i_resp = eir;  v.e_i_rdata = eird; v.e_d_resp = edr;   v.e_d_rdata = edrd;
        v.e_mem_addr = ema; v.e_mem_rmask = erm; v.e_mem_wmask = ewm; v.e_mem_wdata = ewd;
        return v;
    endfunction

    // Grant order expected with both sides always pending: 1 = I, 0 = D.
    logic exp_seq [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        rst = 1'b1;
        i_addr = '0; i_rmask = '0; i_flush = 1'b0;
        d_addr = '0; d_rmask = '0; d_wmask = '0; d_wdata = '0;
        mem_rdata = '0; mem_resp = 1'b0;
        repeat (3) @(negedge clk);

        // I-only fetch, memory latency 3 (rows 0-5)
        vecs.push_back(mk(0,4'hF,32'h6000_0000,0, 0,0,0,0, 0,0,          0,0,0,0, 32'h0,4'h0,4'h0,0));
        vecs.push_back(mk(0,4'hF,32'h6000_0000,0, 0,0,0,0, 0,0,          0,0,0,0, 32'h6000_0000,4'hF,4'h0,0));
        vecs.push_back(mk(0,4'hF,32'h6000_0000,0, 0,0,0,0, 0,0,          0,0,0,0, 32'h6000_0000,4'h0,4'h0,0));
        vecs.push_back(mk(0,4'hF,32'h6000_0000,0, 0,0,0,0, 0,0,          0,0,0,0, 32'h6000_0000,4'h0,4'h0,0));
        vecs.push_back(mk(0,4'hF,32'h6000_0000,0, 0,0,0,0, 1,32'h13,     1,32'h13,0,0, 32'h6000_0000,4'h0,4'h0,0));
        vecs.push_back(mk(0,4'h0,32'h0,0,         0,0,0,0, 0,0,          0,0,0,0, 32'h6000_0000,4'h0,4'h0,0));
        // D store alone (rows 6-9)
        vecs.push_back(mk(0,0,0,0, 4'h0,4'h3,32'h8000_0010,32'hDEAD_BEEF, 0,0,      0,0,0,0, 32'h6000_0000,4'h0,4'h0,0));
        vecs.push_back(mk(0,0,0,0, 4'h0,4'h3,32'h8000_0010,32'hDEAD_BEEF, 0,0,      0,0,0,0, 32'h8000_0010,4'h0,4'h3,32'hDEAD_BEEF));
        vecs.push_back(mk(0,0,0,0, 4'h0,4'h3,32'h8000_0010,32'hDEAD_BEEF, 1,32'h1234, 0,0,1,32'h1234, 32'h8000_0010,4'h0,4'h0,32'hDEAD_BEEF));
        vecs.push_back(mk(0,0,0,0, 4'h0,4'h0,32'h0,32'h0,                 0,0,      0,0,0,0, 32'h8000_0010,4'h0,4'h0,32'hDEAD_BEEF));
        // Flush in I_WAIT, then re-fetch at the new address answered in I_ISSUE (rows 10-16)
        vecs.push_back(mk(0,4'hF,32'h100,0, 0,0,0,0, 0,0,        0,0,0,0, 32'h8000_0010,4'h0,4'h0,32'hDEAD_BEEF));
        vecs.push_back(mk(0,4'hF,32'h100,0, 0,0,0,0, 0,0,        0,0,0,0, 32'h100,4'hF,4'h0,0));
        vecs.push_back(mk(0,4'hF,32'h100,1, 0,0,0,0, 0,0,        0,0,0,0, 32'h100,4'h0,4'h0,0));
        vecs.push_back(mk(0,4'hF,32'h200,0, 0,0,0,0, 1,32'hAA,   0,32'hAA,0,0, 32'h100,4'h0,4'h0,0));
        vecs.push_back(mk(0,4'hF,32'h200,0, 0,0,0,0, 0,0,        0,0,0,0, 32'h100,4'h0,4'h0,0));
        vecs.push_back(mk(0,4'hF,32'h200,0, 0,0,0,0, 1,32'h55,   1,32'h55,0,0, 32'h200,4'hF,4'h0,0));
        vecs.push_back(mk(0,4'h0,32'h0,0,   0,0,0,0, 0,0,        0,0,0,0, 32'h200,4'h0,4'h0,0));
        // Flush in the same cycle as the response (rows 17-19)
        vecs.push_back(mk(0,4'hF,32'h300,0, 0,0,0,0, 0,0,        0,0,0,0, 32'h200,4'h0,4'h0,0));
        vecs.push_back(mk(0,4'hF,32'h300,1, 0,0,0,0, 1,32'h77,   0,32'h77,0,0, 32'h300,4'hF,4'h0,0));
        vecs.push_back(mk(0,4'h0,32'h0,0,   0,0,0,0, 0,0,        0,0,0,0, 32'h300,4'h0,4'h0,0));
        // I request with flush in IDLE is held off one cycle (rows 20-23)
        vecs.push_back(mk(0,4'hF,32'h400,1, 0,0,0,0, 0,0,        0,0,0,0, 32'h300,4'h0,4'h0,0));
        vecs.push_back(mk(0,4'hF,32'h400,0, 0,0,0,0, 0,0,        0,0,0,0, 32'h300,4'h0,4'h0,0));
        vecs.push_back(mk(0,4'hF,32'h400,0, 0,0,0,0, 1,32'h99,   1,32'h99,0,0, 32'h400,4'hF,4'h0,0));
        vecs.push_back(mk(0,4'h0,32'h0,0,   0,0,0,0, 0,0,        0,0,0,0, 32'h400,4'h0,4'h0,0));
        // Reset in D_WAIT, late response two cycles after release (rows 24-29)
        vecs.push_back(mk(0,0,0,0, 4'hF,4'h0,32'h500,0, 0,0,      0,0,0,0, 32'h400,4'h0,4'h0,0));
        vecs.push_back(mk(0,0,0,0, 4'hF,4'h0,32'h500,0, 0,0,      0,0,0,0, 32'h500,4'hF,4'h0,0));
        vecs.push_back(mk(1,0,0,0, 4'hF,4'h0,32'h500,0, 0,0,      0,0,0,0, 32'h500,4'h0,4'h0,0));
        vecs.push_back(mk(0,0,0,0, 4'h0,4'h0,32'h0,0,   0,0,      0,0,0,0, 32'h0,4'h0,4'h0,0));
        vecs.push_back(mk(0,0,0,0, 4'h0,4'h0,32'h0,0,   0,0,      0,0,0,0, 32'h0,4'h0,4'h0,0));
        vecs.push_back(mk(0,0,0,0, 4'h0,4'h0,32'h0,0,   1,32'hBB, 0,0,0,0, 32'h0,4'h0,4'h0,0));
        // Flush does not disturb a D transaction (rows 30-32)
        vecs.push_back(mk(0,0,0,1, 4'hF,4'h0,32'h600,0, 0,0,      0,0,0,0, 32'h0,4'h0,4'h0,0));
        vecs.push_back(mk(0,0,0,1, 4'hF,4'h0,32'h600,0, 1,32'hCC, 0,0,1,32'hCC, 32'h600,4'hF,4'h0,0));
        vecs.push_back(mk(0,0,0,0, 4'h0,4'h0,32'h0,0,   0,0,      0,0,0,0, 32'h600,4'h0,4'h0,0));

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            rst = vecs[k].rst;
            i_rmask = vecs[k].i_rmask;   i_addr = vecs[k].i_addr;   i_flush = vecs[k].i_flush;
            d_rmask = vecs[k].d_rmask;   d_wmask = vecs[k].d_wmask;
            d_addr = vecs[k].d_addr;     d_wdata = vecs[k].d_wdata;
            mem_resp = vecs[k].mem_resp; mem_rdata = vecs[k].mem_rdata;
            #1;
            n_checks++;
            if (i_resp !== vecs[k].e_i_resp || i_rdata !== vecs[k].e_i_rdata ||
                d_resp !== vecs[k].e_d_resp || d_rdata !== vecs[k].e_d_rdata ||
                mem_addr !== vecs[k].e_mem_addr || mem_rmask !== vecs[k].e_mem_rmask ||
                mem_wmask !== vecs[k].e_mem_wmask || mem_wdata !== vecs[k].e_mem_wdata) begin
                n_fail++;
                $display("FAIL vec%0d: got ir=%0b ird=%h dr=%0b drd=%h ma=%h mr=%h mw=%h mwd=%h; want ir=%0b ird=%h dr=%0b drd=%h ma=%h mr=%h mw=%h mwd=%h",
                         k, i_resp, i_rdata, d_resp, d_rdata, mem_addr, mem_rmask, mem_wmask, mem_wdata,
                         vecs[k].e_i_resp, vecs[k].e_i_rdata, vecs[k].e_d_resp, vecs[k].e_d_rdata,
                         vecs[k].e_mem_addr, vecs[k].e_mem_rmask, vecs[k].e_mem_wmask, vecs[k].e_mem_wdata);
            end else begin
                $display("vec%0d ok: mem_addr=%h mem_rmask=%h i_resp=%0b d_resp=%0b", k, mem_addr, mem_rmask, i_resp, d_resp);
            end
        end

        // Grant order with both sides continuously pending; memory answers in the issue cycle.
        @(negedge clk);
        rst = 1'b1;
        i_rmask = 4'h0; d_rmask = 4'h0; d_wmask = 4'h0; i_flush = 1'b0; mem_resp = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        i_rmask = 4'hF; i_addr = 32'h1000;
        d_rmask = 4'hF; d_addr = 32'h2000; d_wdata = 32'h0;
        begin
            int n_grants;
            logic got_i;
            n_grants = 0;
            for (int cyc = 0; cyc < 60 && n_grants < 10; cyc++) begin
                @(negedge clk);
                mem_resp = 1'b0;
                #1;
                if (mem_rmask != 4'h0) begin
                    got_i = (mem_addr == 32'h1000);
                    mem_resp = 1'b1;
                    mem_rdata = 32'(cyc);
                    #1;
                    n_checks++;
                    if (got_i !== exp_seq[n_grants] || i_resp !== got_i || d_resp !== !got_i) begin
                        n_fail++;
                        $display("FAIL grant%0d: got side=%s i_resp=%0b d_resp=%0b; want side=%s",
                                 n_grants, got_i ? "I" : "D", i_resp, d_resp, exp_seq[n_grants] ? "I" : "D");
                    end else begin
                        $display("grant%0d ok: side=%s addr=%h", n_grants, got_i ? "I" : "D", mem_addr);
                    end
                    n_grants++;
                end
            end
            mem_resp = 1'b0;
            n_checks++;
            if (n_grants != 10) begin
                n_fail++;
                $display("FAIL grant_timeout: got %0d grants, want 10", n_grants);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
